// File: rtl/packet_store_forward_pkg.sv
// Shared types and helpers for the packet_store_forward buffer.
//   entry_t    : layout of one stored word at the default payload width
//   wr_state_t : write-side framing state
//   ptr_w()    : pointer width for a given depth (one extra wrap bit)
package packet_store_forward_pkg;

  localparam int DATA_W_DFLT = 32;

  typedef struct packed {
    logic                   first;
    logic                   last;
    logic [DATA_W_DFLT-1:0] payload;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  // The extra MSB lets equal low bits mean either empty or full.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/packet_store_forward_ram.sv
// Simple dual-port storage for packet_store_forward.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data ({first, last, payload})
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
// Contents are not reset; validity is tracked entirely by the pointers.
module packet_store_forward_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 34,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/packet_store_forward.sv
// Store-and-forward packet buffer.
// Accepts a first/last framed word stream and only releases a packet once
// its last word has been stored. Incomplete, malformed or oversized packets
// are rolled back and counted, so the output only ever carries whole packets.
//   clk, rst_n                : clock, async active-low reset
//   valid_rx/ready_rx         : input handshake (ready_rx never drops after reset)
//   first_rx/last_rx/payload_rx : input word and framing
//   valid_tx/ready_tx         : output handshake (AXI-stream hold rules)
//   first_tx/last_tx/payload_tx : output word and framing
//   drop_count                : discarded packets, saturating
//   level                     : words held in storage, committed or not
module packet_store_forward
  import packet_store_forward_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_rx,
  output logic                   ready_rx,
  input  logic                   first_rx,
  input  logic                   last_rx,
  input  logic [DATA_W-1:0]      payload_rx,
  output logic                   valid_tx,
  input  logic                   ready_tx,
  output logic                   first_tx,
  output logic                   last_tx,
  output logic [DATA_W-1:0]      payload_tx,
  output logic [CNT_W-1:0]       drop_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int            PW   = ptr_w(DEPTH);
  localparam int            AW   = PW - 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  // Same layout as entry_t, but sized by this instance's DATA_W.
  typedef struct packed {
    logic              first;
    logic              last;
    logic [DATA_W-1:0] payload;
  } ent_t;

  wr_state_t     state_q;
  logic [PW-1:0] wr_ptr_q, wr_commit_q, rd_ptr_q, pkt_count_q;
  logic          ready_q;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic          tx_vld_q;
  ent_t          tx_q, rd_ent, wr_ent;

  logic          rx_fire, frame_err, wr_go, full, wr_ok, ovf, commit;
  logic          load, pop_last;
  logic [PW-1:0] base_ptr;
  logic [1:0]    drops;
  logic [CNT_W:0] drop_sum;

  // ---------------------------------------------------------------- write side
  assign rx_fire   = valid_rx & ready_q;
  // A new first word while a packet is open abandons the open packet.
  assign frame_err = rx_fire & (state_q == RECV) & first_rx;
  // Words that try to enter storage: anything inside a packet, or a new start.
  assign wr_go     = rx_fire & ((state_q == RECV) | first_rx);
  // On a framing error the new packet starts where the abandoned one began,
  // so space is judged against the rolled-back pointer.
  assign base_ptr  = frame_err ? wr_commit_q : wr_ptr_q;
  assign full      = (base_ptr - rd_ptr_q) == FULL;
  assign wr_ok     = wr_go & ~full;
  assign ovf       = wr_go & full;
  assign commit    = wr_ok & last_rx;
  assign wr_ent    = {first_rx, last_rx, payload_rx};

  // A framing error followed by overflow of the restarted packet drops two.
  assign drops    = {1'b0, frame_err} + {1'b0, ovf};
  assign drop_sum = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drops};
  assign drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      drop_q      <= '0;
    end else begin
      drop_q <= drop_d;
      if (ovf) begin
        // Discard the whole open packet; a word that was also last needs no
        // drop phase since nothing of its packet remains upstream.
        wr_ptr_q <= wr_commit_q;
        state_q  <= last_rx ? IDLE : DROP;
      end else if (wr_ok) begin
        wr_ptr_q <= base_ptr + PW'(1);
        if (last_rx) begin
          wr_commit_q <= base_ptr + PW'(1);
          state_q     <= IDLE;
        end else begin
          state_q <= RECV;
        end
      end else if (rx_fire && state_q == DROP && last_rx) begin
        state_q <= IDLE;
      end
    end
  end

  packet_store_forward_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 2)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_ok),
    .waddr_i (base_ptr[AW-1:0]),
    .wdata_i (wr_ent),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_ent)
  );

  // ----------------------------------------------------------------- read side
  // pkt_count > 0 guarantees rd_ptr sits on committed data, so the read side
  // can never overtake wr_commit.
  assign load     = (pkt_count_q != '0) & (~tx_vld_q | ready_tx);
  assign pop_last = load & rd_ent.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      pkt_count_q <= '0;
      rd_ptr_q    <= '0;
      tx_vld_q    <= 1'b0;
      tx_q        <= '0;
    end else begin
      ready_q <= 1'b1;

      if (commit && !pop_last)      pkt_count_q <= pkt_count_q + PW'(1);
      else if (!commit && pop_last) pkt_count_q <= pkt_count_q - PW'(1);

      if (load) begin
        tx_vld_q <= 1'b1;
        tx_q     <= rd_ent;
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end else if (ready_tx) begin
        tx_vld_q <= 1'b0;
        tx_q     <= '0;
      end
    end
  end

  assign ready_rx   = ready_q;
  assign valid_tx   = tx_vld_q;
  assign first_tx   = tx_q.first;
  assign last_tx    = tx_q.last;
  assign payload_tx = tx_q.payload;
  assign drop_count = drop_q;
  assign level      = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_packet_store_forward.sv
// Self-checking bench for packet_store_forward: directed scenarios plus a
// randomized phase, checked against a packet-level reference model.
module tb_packet_store_forward;

  localparam int DEPTH  = 64;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_rx, first_rx, last_rx, ready_rx;
  logic [DATA_W-1:0] payload_rx;
  logic              valid_tx, ready_tx, first_tx, last_tx;
  logic [DATA_W-1:0] payload_tx;
  logic [CNT_W-1:0]  drop_count;
  logic [6:0]        level;

  always #5 clk = ~clk;

  packet_store_forward #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_rx   (valid_rx),
    .ready_rx   (ready_rx),
    .first_rx   (first_rx),
    .last_rx    (last_rx),
    .payload_rx (payload_rx),
    .valid_tx   (valid_tx),
    .ready_tx   (ready_tx),
    .first_tx   (first_tx),
    .last_tx    (last_tx),
    .payload_tx (payload_tx),
    .drop_count (drop_count),
    .level      (level)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Packets are collected word by word; a packet reaches the expected output
  // queue only when its last word arrives intact. The overflow rule assumes
  // the store is otherwise empty, which holds wherever a packet can be that long.
  typedef struct packed {
    logic              f;
    logic              l;
    logic [DATA_W-1:0] d;
  } wd_t;

  wd_t exp_q[$];
  wd_t part_q[$];
  bit  m_recv    = 1'b0;
  int  exp_drops = 0;

  function automatic void model_word(input logic f, input logic l, input logic [DATA_W-1:0] d);
    wd_t w;
    w = {f, l, d};
    if (f) begin
      if (m_recv) exp_drops++;
      part_q.delete();
      m_recv = 1'b1;
    end else if (!m_recv) begin
      return;
    end
    if (part_q.size() == DEPTH) begin
      exp_drops++;
      part_q.delete();
      m_recv = 1'b0;
      return;
    end
    part_q.push_back(w);
    if (l) begin
      foreach (part_q[i]) exp_q.push_back(part_q[i]);
      part_q.delete();
      m_recv = 1'b0;
    end
  endfunction

  task automatic send(input logic f, input logic l, input logic [DATA_W-1:0] d);
    valid_rx   = 1'b1;
    first_rx   = f;
    last_rx    = l;
    payload_rx = d;
    model_word(f, l, d);
    @(posedge clk); #1;
    valid_rx = 1'b0;
    first_rx = 1'b0;
    last_rx  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_pending_words"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------- monitor
  // Sampled on the falling edge: an accepted word is one with valid_tx and
  // ready_tx both high here, since inputs only change just after rising edges.
  initial begin : mon
    wd_t w, sw;
    logic sv;
    sv = 1'b0;
    sw = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sv = 1'b0;
      end else begin
        if (sv) chk("tx_hold", {valid_tx, first_tx, last_tx, payload_tx}, {1'b1, sw});
        if (valid_tx && ready_tx) begin
          if (exp_q.size() == 0) begin
            chk("tx_unexpected_valid", 64'(valid_tx), 64'd0);
          end else begin
            w = exp_q.pop_front();
            chk("tx_word", {first_tx, last_tx, payload_tx}, w);
          end
        end
        sv = valid_tx && !ready_tx;
        sw = {first_tx, last_tx, payload_tx};
      end
    end
  end

  bit rnd_stop;

  // ------------------------------------------------------------ stimulus
  initial begin
    int t, kind, len;
    rst_n      = 1'b0;
    valid_rx   = 1'b0;
    first_rx   = 1'b0;
    last_rx    = 1'b0;
    payload_rx = '0;
    ready_tx   = 1'b0;
    rnd_stop   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_rx", 64'(ready_rx), 64'd0);
    chk("rst_valid_tx", 64'(valid_tx), 64'd0);
    chk("rst_flags_payload", {first_tx, last_tx, payload_tx}, 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_rx_before_edge", 64'(ready_rx), 64'd0);
    @(posedge clk); #1;
    chk("ready_rx_after_edge", 64'(ready_rx), 64'd1);

    // Single packet and latency: valid_tx stays low for the edge that commits
    // and rises on the following edge with the first word.
    ready_tx = 1'b1;
    send(1'b1, 1'b0, 32'hA0);
    send(1'b0, 1'b0, 32'hA1);
    send(1'b0, 1'b1, 32'hA2);
    chk("lat_valid_after_commit", 64'(valid_tx), 64'd0);
    @(posedge clk); #1;
    chk("lat_valid_next_cycle", 64'(valid_tx), 64'd1);
    chk("lat_first_word", {first_tx, last_tx, payload_tx}, {2'b10, 32'hA0});
    wait_drain("single");
    chk("single_level", 64'(level), 64'd0);
    chk("single_drop_count", 64'(drop_count), 64'(exp_drops));

    // Back-pressure: two 4-word packets while stalled. The first packet's head
    // word has already moved into the output register, so storage holds 7.
    ready_tx = 1'b0;
    for (int i = 0; i < 8; i++) send(i % 4 == 0, i % 4 == 3, 32'h100 + i);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_level_peak", 64'(level), 64'd7);
    chk("bp_head_word", {valid_tx, first_tx, last_tx, payload_tx}, {3'b110, 32'h100});
    ready_tx = 1'b1;
    wait_drain("bp");
    chk("bp_level_empty", 64'(level), 64'd0);

    // Framing error: second first word abandons the open packet.
    send(1'b1, 1'b0, 32'h1);
    send(1'b0, 1'b0, 32'h2);
    send(1'b1, 1'b0, 32'h3);
    send(1'b0, 1'b1, 32'h4);
    wait_drain("frame");
    chk("frame_drop_count", 64'(drop_count), 64'(exp_drops));

    // Overflow: a 70-word packet cannot fit in 64 entries.
    ready_tx = 1'b0;
    for (int i = 0; i < 70; i++) send(i == 0, i == 69, 32'h200 + i);
    send(1'b1, 1'b0, 32'hB0);
    send(1'b0, 1'b1, 32'hB1);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_drop_count", 64'(drop_count), 64'(exp_drops));
    ready_tx = 1'b1;
    wait_drain("ovf");
    chk("ovf_level", 64'(level), 64'd0);

    // Orphan words are discarded silently; then a single-word packet.
    send(1'b0, 1'b0, 32'hE1);
    send(1'b0, 1'b1, 32'hE2);
    send(1'b0, 1'b0, 32'hE3);
    repeat (4) @(posedge clk);
    #1;
    chk("orphan_level", 64'(level), 64'd0);
    chk("orphan_drop_count", 64'(drop_count), 64'(exp_drops));
    send(1'b1, 1'b1, 32'hC5);
    @(posedge clk); #1;
    chk("single_word_pkt", {valid_tx, first_tx, last_tx, payload_tx}, {3'b111, 32'hC5});
    wait_drain("single_word");

    // Randomized traffic with random downstream stalls.
    fork
      begin
        while (!rnd_stop) begin
          @(posedge clk); #1;
          ready_tx = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int p = 0; p < 60; p++) begin
      t = 0;
      while (level >= 40 && t < 500) begin
        @(posedge clk); #1;
        t++;
      end
      chk("rnd_level_bound", 64'(level < 40), 64'd1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 8);
      if (kind == 0) begin
        for (int i = 0; i < len % 3 + 1; i++) send(1'b0, 1'($urandom_range(0, 1)), $urandom);
      end else if (kind == 1) begin
        for (int i = 0; i < len; i++) send(i == 0, 1'b0, $urandom);
      end else begin
        for (int i = 0; i < len; i++) send(i == 0, i == len - 1, $urandom);
      end
    end
    rnd_stop = 1'b1;
    @(posedge clk); #2;
    ready_tx = 1'b1;
    wait_drain("rnd");
    chk("rnd_drop_count", 64'(drop_count), 64'(exp_drops));

    // Reset mid-packet: one committed packet pending, half a packet open.
    ready_tx = 1'b0;
    send(1'b1, 1'b0, 32'h300);
    send(1'b0, 1'b1, 32'h301);
    send(1'b1, 1'b0, 32'h310);
    send(1'b0, 1'b0, 32'h311);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_tx", 64'(valid_tx), 64'd0);
    chk("mid_rst_flags_payload", {first_tx, last_tx, payload_tx}, 64'd0);
    chk("mid_rst_drop_count", 64'(drop_count), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_ready_rx", 64'(ready_rx), 64'd0);
    exp_q.delete();
    part_q.delete();
    m_recv    = 1'b0;
    exp_drops = 0;
    @(negedge clk);
    rst_n    = 1'b1;
    ready_tx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_level", 64'(level), 64'd0);
    chk("post_rst_valid_tx", 64'(valid_tx), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
